raster_sequencer: RTL and testbench
===================================

Name: raster_sequencer

Overview:
- Sequences one latched draw command into a stream of single-pixel writes toward the 8x8 framebuffer.
- Sits between the command-latching front end (consumes its command fields plus a one-cycle valid pulse) and the framebuffer write port.
- Executes CLEAR, POINT, RECT fill and LINE (Bresenham), one pixel per accepted write, with ready/valid backpressure.

Parameters:
- GRID_BITS, 3, coordinate width; grid is 2**GRID_BITS square (8x8).
- DRAW_VAL, 1'b1, pixel value written by POINT/RECT/LINE; CLEAR always writes 0.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- cmd_valid  in  1  one-cycle command strobe
- cmd  in  2  opcode: 00 CLEAR, 01 POINT, 10 RECT, 11 LINE
- x1, y1, x2, y2  in  3 each  endpoints / origin
- width, height  in  3 each  RECT size minus one (0 = 1 pixel)
- busy  out  1  high from accept until done
- cmd_drop  out  1  one-cycle pulse: cmd_valid arrived while busy
- pix_we  out  1  write request (valid)
- pix_ready  in  1  framebuffer accepts the write this cycle
- pix_x, pix_y  out  3 each  write coordinate
- pix_val  out  1  write data
- done  out  1  one-cycle pulse after the last write is accepted

Behaviour:
- Reset (rst high at a clk edge): state IDLE; busy, cmd_drop, pix_we, pix_x, pix_y, pix_val, done all 0; line registers cleared. Reset mid-command aborts with no further writes.
- Command capture: in IDLE, cmd_valid=1 latches all fields, asserts busy next cycle, enters the opcode's state. First pix_we appears the cycle after capture (latency 1).
- cmd_valid while busy (including the done cycle): ignored, cmd_drop pulses next cycle, current command unaffected.
- Write handshake: pix_we/pix_x/pix_y/pix_val stay stable until a cycle with pix_we & pix_ready. The next pixel is presented the following cycle with no bubble. pix_ready with pix_we low is ignored.
- States: IDLE, CLEAR, POINT, RECT, LINE, FINISH.
- CLEAR: 64 writes, pix_val=0, raster order (y outer, x inner), (0,0) to (7,7).
- POINT: single write at (x1,y1).
- RECT: x from x1 to min(x1+width,7), y from y1 to min(y1+height,7). Row-major, y outer. Clipped at 7, never wraps. Sums use 4-bit width.
- LINE: init dx=|x2-x1|, dy=-|y2-y1|, sx/sy=+1 or -1 (+1 when equal), err=dx+dy (6-bit signed).
  - Per accepted pixel: if (x,y)==(x2,y2), finish.
  - Else e2=2*err (7-bit signed); if e2>=dy then err+=dy, x+=sx; if e2<=dx then err+=dx, y+=sy. Both updates use the pre-update err.
  - x1==x2 and y1==y2 gives one write.
- FINISH: entered after the last accepted write. done=1 for exactly one cycle, busy drops with done, state returns to IDLE. A command can be captured the cycle after done.
- pix_x/pix_y hold their last value while idle.

Decomposition:
- Shared package raster_pkg: opcode constants (OP_CLEAR, OP_POINT, OP_RECT, OP_LINE), state encodings, GRID_BITS/GRID_MAX=7.
- One natural sub-module: raster_line_stepper (Bresenham init/step). Interface: load, step, current x/y, at_end flag.
- CLEAR/RECT counters remain in the top level.

Test Plan:
- CLEAR, pix_ready tied 1 -> 64 consecutive writes, first (0,0), last (7,7), pix_val=0 throughout. done one cycle after last write. busy high for 65 cycles.
- POINT x1=3,y1=5 -> exactly one write (3,5) val 1, then done. RECT x1=6,y1=6,w=3,h=1 -> writes (6,6),(7,6),(6,7),(7,7) only.
- LINE (0,0)->(7,3) -> writes (0,0),(1,0),(2,1),(3,1),(4,2),(5,2),(6,3),(7,3). Reverse (7,3)->(0,0) gives 8 writes ending (0,0). LINE (4,4)->(4,4) gives one write.
- Backpressure: RECT 2x2 with pix_ready toggling 1,0,0,1,... -> coordinates stable while stalled, no pixel skipped or duplicated, 4 writes total.
- cmd_valid during busy LINE -> cmd_drop pulses once, line output unchanged. cmd_valid the cycle after done -> accepted.
- rst asserted mid-CLEAR (after 10 writes) -> next cycle pix_we=0, busy=0, no done. A new POINT then executes normally.

Source files
------------

// File: rtl/raster_pkg.sv
// Shared opcode, state and grid definitions for the raster sequencer slice.
package raster_pkg;
  localparam int GRID_BITS = 3;
  localparam int GRID_MAX  = (1 << GRID_BITS) - 1;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_POINT = 2'b01;
  localparam logic [1:0] OP_RECT  = 2'b10;
  localparam logic [1:0] OP_LINE  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_POINT, S_RECT, S_LINE, S_FINISH
  } state_e;
endpackage

// File: rtl/raster_line_stepper.sv
// Bresenham walker: load latches endpoints, each step advances one pixel toward the end.
module raster_line_stepper #(
  parameter int GRID_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [GRID_BITS-1:0] x1,
  input  logic [GRID_BITS-1:0] y1,
  input  logic [GRID_BITS-1:0] x2,
  input  logic [GRID_BITS-1:0] y2,
  output logic [GRID_BITS-1:0] x,
  output logic [GRID_BITS-1:0] y,
  output logic                 at_end
);
  localparam int EW = GRID_BITS + 3;

  logic [GRID_BITS-1:0] xe, ye, adx, ady;
  logic                 sx_neg, sy_neg, mv_x, mv_y;
  logic signed [EW-1:0] dx, dy, err, err_n;
  logic signed [EW:0]   e2;

  always_comb begin
    adx    = (x2 >= x1) ? x2 - x1 : x1 - x2;
    ady    = (y2 >= y1) ? y2 - y1 : y1 - y2;
    e2     = {err, 1'b0};
    mv_x   = (e2 >= dy);
    mv_y   = (e2 <= dx);
    // both corrections are taken from the same pre-step error term
    err_n  = err + (mv_x ? dy : '0) + (mv_y ? dx : '0);
    at_end = (x == xe) && (y == ye);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x <= '0; y <= '0; xe <= '0; ye <= '0;
      dx <= '0; dy <= '0; err <= '0;
      sx_neg <= 1'b0; sy_neg <= 1'b0;
    end else if (load) begin
      x      <= x1;
      y      <= y1;
      xe     <= x2;
      ye     <= y2;
      sx_neg <= (x2 < x1);
      sy_neg <= (y2 < y1);
      dx     <= EW'(adx);
      dy     <= '0 - EW'(ady);
      err    <= EW'(adx) - EW'(ady);
    end else if (step && !at_end) begin
      err <= err_n;
      if (mv_x) x <= sx_neg ? x - 1'b1 : x + 1'b1;
      if (mv_y) y <= sy_neg ? y - 1'b1 : y + 1'b1;
    end
  end
endmodule

// File: rtl/raster_sequencer.sv
// Turns one latched draw command into a ready/valid stream of single-pixel writes.
module raster_sequencer #(
  parameter int   GRID_BITS = 3,
  parameter logic DRAW_VAL  = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd,
  input  logic [GRID_BITS-1:0] x1,
  input  logic [GRID_BITS-1:0] y1,
  input  logic [GRID_BITS-1:0] x2,
  input  logic [GRID_BITS-1:0] y2,
  input  logic [GRID_BITS-1:0] width,
  input  logic [GRID_BITS-1:0] height,
  output logic                 busy,
  output logic                 cmd_drop,
  output logic                 pix_we,
  input  logic                 pix_ready,
  output logic [GRID_BITS-1:0] pix_x,
  output logic [GRID_BITS-1:0] pix_y,
  output logic                 pix_val,
  output logic                 done
);
  import raster_pkg::*;

  localparam logic [GRID_BITS-1:0] CMAX = '1;

  state_e               state, state_n;
  logic                 we_q, we_n, val_q, val_n, drop_q, drop_n;
  logic [GRID_BITS-1:0] px_q, px_n, py_q, py_n;
  logic [GRID_BITS-1:0] rx0_q, rx0_n, rxe_q, rxe_n, rye_q, rye_n;
  logic [GRID_BITS:0]   xsum, ysum;
  logic                 accept, ln_load, ln_step, ln_end;
  logic [GRID_BITS-1:0] ln_x, ln_y;

  raster_line_stepper #(.GRID_BITS(GRID_BITS)) u_line (
    .clk(clk), .rst(rst), .load(ln_load), .step(ln_step),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .x(ln_x), .y(ln_y), .at_end(ln_end)
  );

  assign accept   = we_q & pix_ready;
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_FINISH);
  assign pix_we   = we_q;
  assign pix_val  = val_q;
  assign cmd_drop = drop_q;
  // the stepper owns the coordinate while a line is running
  assign pix_x    = (state == S_LINE) ? ln_x : px_q;
  assign pix_y    = (state == S_LINE) ? ln_y : py_q;

  always_comb begin
    state_n = state;
    we_n    = we_q;
    val_n   = val_q;
    px_n    = px_q;
    py_n    = py_q;
    rx0_n   = rx0_q;
    rxe_n   = rxe_q;
    rye_n   = rye_q;
    drop_n  = cmd_valid && (state != S_IDLE);
    ln_load = 1'b0;
    ln_step = 1'b0;
    xsum    = {1'b0, x1} + {1'b0, width};
    ysum    = {1'b0, y1} + {1'b0, height};
    case (state)
      S_IDLE: if (cmd_valid) begin
        we_n  = 1'b1;
        val_n = DRAW_VAL;
        px_n  = x1;
        py_n  = y1;
        case (cmd)
          OP_CLEAR: begin
            state_n = S_CLEAR;
            val_n   = 1'b0;
            px_n    = '0;
            py_n    = '0;
          end
          OP_POINT: state_n = S_POINT;
          OP_RECT: begin
            state_n = S_RECT;
            rx0_n   = x1;
            // carry out of the sum means the far edge ran past the grid
            rxe_n   = xsum[GRID_BITS] ? CMAX : xsum[GRID_BITS-1:0];
            rye_n   = ysum[GRID_BITS] ? CMAX : ysum[GRID_BITS-1:0];
          end
          OP_LINE: begin
            state_n = S_LINE;
            ln_load = 1'b1;
          end
        endcase
      end
      S_CLEAR: if (accept) begin
        if (px_q == CMAX && py_q == CMAX) begin
          we_n    = 1'b0;
          state_n = S_FINISH;
        end else if (px_q == CMAX) begin
          px_n = '0;
          py_n = py_q + 1'b1;
        end else begin
          px_n = px_q + 1'b1;
        end
      end
      S_POINT: if (accept) begin
        we_n    = 1'b0;
        state_n = S_FINISH;
      end
      S_RECT: if (accept) begin
        if (px_q == rxe_q && py_q == rye_q) begin
          we_n    = 1'b0;
          state_n = S_FINISH;
        end else if (px_q == rxe_q) begin
          px_n = rx0_q;
          py_n = py_q + 1'b1;
        end else begin
          px_n = px_q + 1'b1;
        end
      end
      S_LINE: if (accept) begin
        if (ln_end) begin
          we_n    = 1'b0;
          state_n = S_FINISH;
          px_n    = ln_x;
          py_n    = ln_y;
        end else begin
          ln_step = 1'b1;
        end
      end
      S_FINISH: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      we_q   <= 1'b0;
      val_q  <= 1'b0;
      drop_q <= 1'b0;
      px_q   <= '0;
      py_q   <= '0;
      rx0_q  <= '0;
      rxe_q  <= '0;
      rye_q  <= '0;
    end else begin
      state  <= state_n;
      we_q   <= we_n;
      val_q  <= val_n;
      drop_q <= drop_n;
      px_q   <= px_n;
      py_q   <= py_n;
      rx0_q  <= rx0_n;
      rxe_q  <= rxe_n;
      rye_q  <= rye_n;
    end
  end
endmodule

// File: tb/tb_raster_sequencer.sv
// Directed bench for raster_sequencer: logs accepted writes and compares against hand-built lists.
module tb_raster_sequencer;
  logic       clk = 1'b0, rst = 1'b1, cmd_valid = 1'b0, pix_ready = 1'b1;
  logic [1:0] cmd = 2'b00;
  logic [2:0] x1 = '0, y1 = '0, x2 = '0, y2 = '0, width = '0, height = '0;
  logic       busy, cmd_drop, pix_we, pix_val, done;
  logic [2:0] pix_x, pix_y;

  raster_sequencer dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .width(width), .height(height),
    .busy(busy), .cmd_drop(cmd_drop), .pix_we(pix_we), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_val(pix_val), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic int enc(input int v, input int x, input int y);
    return v * 64 + x * 8 + y;
  endfunction

  // write log and event counters, sampled on the falling edge
  int   wq[$];
  int   cyc = 0, last_wr = 0, done_cyc = 0, done_cnt = 0, busy_cnt = 0, drop_cnt = 0, stab_err = 0;
  logic prev_stall = 1'b0, prev_val = 1'b0;
  logic [2:0] prev_x = '0, prev_y = '0;
  always @(negedge clk) begin
    cyc++;
    if (prev_stall && (!pix_we || pix_x != prev_x || pix_y != prev_y || pix_val != prev_val))
      stab_err++;
    prev_stall = pix_we && !pix_ready;
    prev_x = pix_x; prev_y = pix_y; prev_val = pix_val;
    if (pix_we && pix_ready) begin
      wq.push_back(enc(int'(pix_val), int'(pix_x), int'(pix_y)));
      last_wr = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (busy) busy_cnt++;
    if (cmd_drop) drop_cnt++;
  end

  // ready source: steady 1, or the 1,0,0,1 stall pattern
  logic       bp = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int         bp_k = 0;
  always @(posedge clk) begin
    #1;
    if (bp) begin pix_ready = bp_pat[bp_k % 4]; bp_k++; end
    else pix_ready = 1'b1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_log();
    wq.delete(); done_cnt = 0; busy_cnt = 0; drop_cnt = 0;
  endtask

  int first_we = 0;
  task automatic run_cmd(input logic [1:0] op, input int ax1, input int ay1, input int ax2,
                         input int ay2, input int aw, input int ah, input int inj);
    bit seen = 0;
    clr_log();
    cmd = op; x1 = 3'(ax1); y1 = 3'(ay1); x2 = 3'(ax2); y2 = 3'(ay2);
    width = 3'(aw); height = 3'(ah); cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    first_we = int'(pix_we);
    for (int n = 0; n < 300; n++) begin
      cmd_valid = (n == inj);
      if (n == inj) begin cmd = 2'b01; x1 = 3'd1; y1 = 3'd1; end
      tick();
      if (done) begin seen = 1; break; end
    end
    cmd_valid = 1'b0;
    if (!seen) chk("timeout", 0, 1);
    else tick();
  endtask

  task automatic cmp_list(input string tag, input int exp[$]);
    chk({tag, "_count"}, wq.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk($sformatf("%s[%0d]", tag, i), (i < wq.size()) ? wq[i] : -1, exp[i]);
  endtask

  initial begin
    int exp[$];
    int bad, n_wr;
    repeat (3) tick();
    chk("rst_busy", int'(busy), 0);
    chk("rst_we", int'(pix_we), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_drop", int'(cmd_drop), 0);
    chk("rst_x", int'(pix_x), 0);
    chk("rst_y", int'(pix_y), 0);
    rst = 1'b0;
    tick();

    run_cmd(2'b00, 0, 0, 0, 0, 0, 0, -1);
    chk("clear_latency", first_we, 1);
    chk("clear_count", wq.size(), 64);
    bad = 0;
    for (int i = 0; i < wq.size(); i++) if (wq[i] != enc(0, i % 8, i / 8)) bad++;
    chk("clear_order", bad, 0);
    chk("clear_first", (wq.size() > 0) ? wq[0] : -1, enc(0, 0, 0));
    chk("clear_last", (wq.size() == 64) ? wq[63] : -1, enc(0, 7, 7));
    chk("clear_done", done_cnt, 1);
    chk("clear_done_lag", done_cyc - last_wr, 1);
    chk("clear_busy", busy_cnt, 65);

    run_cmd(2'b01, 3, 5, 0, 0, 0, 0, -1);
    exp = '{enc(1, 3, 5)};
    cmp_list("point", exp);
    chk("point_done", done_cnt, 1);

    run_cmd(2'b10, 6, 6, 0, 0, 3, 1, -1);
    exp = '{enc(1, 6, 6), enc(1, 7, 6), enc(1, 6, 7), enc(1, 7, 7)};
    cmp_list("rect_clip", exp);

    run_cmd(2'b11, 0, 0, 7, 3, 0, 0, -1);
    exp = '{enc(1, 0, 0), enc(1, 1, 0), enc(1, 2, 1), enc(1, 3, 1),
            enc(1, 4, 2), enc(1, 5, 2), enc(1, 6, 3), enc(1, 7, 3)};
    cmp_list("line_fwd", exp);

    run_cmd(2'b11, 7, 3, 0, 0, 0, 0, -1);
    exp = '{enc(1, 7, 3), enc(1, 6, 3), enc(1, 5, 2), enc(1, 4, 2),
            enc(1, 3, 1), enc(1, 2, 1), enc(1, 1, 0), enc(1, 0, 0)};
    cmp_list("line_rev", exp);
    chk("line_rev_x", int'(pix_x), 0);

    run_cmd(2'b11, 4, 4, 4, 4, 0, 0, -1);
    exp = '{enc(1, 4, 4)};
    cmp_list("line_dot", exp);

    bp = 1'b1; bp_k = 0;
    run_cmd(2'b10, 1, 2, 0, 0, 1, 1, -1);
    bp = 1'b0;
    exp = '{enc(1, 1, 2), enc(1, 2, 2), enc(1, 1, 3), enc(1, 2, 3)};
    cmp_list("rect_bp", exp);
    chk("rect_bp_stable", stab_err, 0);

    run_cmd(2'b11, 0, 0, 7, 3, 0, 0, 2);
    exp = '{enc(1, 0, 0), enc(1, 1, 0), enc(1, 2, 1), enc(1, 3, 1),
            enc(1, 4, 2), enc(1, 5, 2), enc(1, 6, 3), enc(1, 7, 3)};
    cmp_list("line_drop", exp);
    chk("drop_pulses", drop_cnt, 1);

    run_cmd(2'b01, 6, 1, 0, 0, 0, 0, -1);
    exp = '{enc(1, 6, 1)};
    cmp_list("after_done", exp);
    chk("after_done_drop", drop_cnt, 0);

    clr_log();
    cmd = 2'b00; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int n = 0; n < 200 && wq.size() < 10; n++) tick();
    rst = 1'b1;
    tick();
    chk("rst_mid_we", int'(pix_we), 0);
    chk("rst_mid_busy", int'(busy), 0);
    rst = 1'b0;
    n_wr = wq.size();
    chk("rst_mid_writes", n_wr, 11);
    repeat (5) tick();
    chk("rst_mid_quiet", wq.size(), n_wr);
    chk("rst_mid_nodone", done_cnt, 0);

    run_cmd(2'b01, 2, 4, 0, 0, 0, 0, -1);
    exp = '{enc(1, 2, 4)};
    cmp_list("post_rst_point", exp);
    chk("post_rst_done", done_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
